bios_shadow_ctrl: RTL and testbench
===================================

Name: bios_shadow_ctrl

Overview:
Boot-time sequencer that copies the 8 KiB BIOS ROM image into system SRAM at FE000h–FFFFFh while the CPU is held in reset. It then hands the ROM read port back to the CPU bus.
- Sits between the CPU bus decode, the BIOS ROM block (registered, 1-cycle read latency, select + data outputs) and the SRAM write port.
- Also computes the PC-style 8-bit BIOS checksum for a boot-status LED or register.

Parameters:
ROM_BYTES, 8192, number of bytes copied; power of two.
IDX_W, 13, index width, log2(ROM_BYTES).
BASE_ADDR, 20'hFE000, first physical address of the ROM window and of the SRAM shadow.

Ports:
iClk  in  1  system clock
iRst  in  1  reset, asynchronous, active-high
iStart  in  1  1-cycle pulse; re-runs the copy when in DONE
iCpuAddr  in  20  CPU bus address
iCpuRd  in  1  CPU bus read strobe
oRomAddr  out  20  address to BIOS ROM block
oRomRd  out  1  read strobe to BIOS ROM block
iRomSel  in  1  ROM select, valid 1 cycle after oRomRd
iRomData  in  8  ROM data, valid 1 cycle after oRomRd
oMemAddr  out  20  SRAM write address
oMemData  out  8  SRAM write data
oMemWr  out  1  SRAM write request, held until iMemAck
iMemAck  in  1  SRAM write accepted (same-cycle)
oCpuHold  out  1  holds CPU in reset while high
oDone  out  1  copy finished successfully
oError  out  1  ROM did not respond during copy
oSumOk  out  1  valid when oDone; 8-bit sum of all bytes == 0
oChecksum  out  8  running 8-bit byte sum

Behaviour:
- One clock (iClk). iRst is asynchronous, active-high, and wins over every other input.
- Reset values:
  - state = READ, idx = 0, sum = 0.
  - oCpuHold = 1; oDone = 0; oError = 0; oSumOk = 0; oChecksum = 0.
  - oMemWr = 0; oMemAddr = 0; oMemData = 0; oRomRd = 0.
- States: READ, CAPTURE, WRITE, DONE, ERROR.
- READ:
  - oRomRd = 1, oRomAddr = BASE_ADDR + idx.
  - Next state: CAPTURE.
- CAPTURE:
  - Sample iRomSel and iRomData.
  - iRomSel = 0 → go to ERROR.
  - Otherwise latch the data byte, sum <= sum + data (mod 256), go to WRITE.
- WRITE:
  - oMemWr = 1, oMemAddr = BASE_ADDR + idx, oMemData = latched byte.
  - Address and data stay stable until a cycle with iMemAck = 1.
  - On ack with idx == ROM_BYTES-1 → DONE. On ack otherwise → idx++, go to READ.
- Throughput: 3 cycles per byte with immediate ack.
  - Full copy = 3·ROM_BYTES cycles from the first READ to oDone = 1.
- DONE:
  - oDone = 1, oCpuHold = 0.
  - oSumOk = (sum == 0), registered on entry.
  - ROM port passes through combinationally: oRomAddr = iCpuAddr, oRomRd = iCpuRd.
  - oMemWr = 0.
- iStart in DONE: clear idx, sum, oDone and oSumOk; set oCpuHold = 1; go to READ. iStart in any other state is ignored.
- ERROR:
  - oError = 1 and oCpuHold = 1, permanently. Leave only via iRst.
  - oRomRd = 0 and oMemWr = 0.
- While not in DONE, CPU bus inputs are ignored. oRomRd is 0 in CAPTURE, WRITE and ERROR.
- Reset mid-WRITE: oMemWr drops asynchronously and the copy restarts from idx 0 once reset is released.
- idx does not wrap. The terminal index is compared explicitly; the idx register is IDX_W bits.
- oChecksum = sum register, updated in CAPTURE.

Decomposition:
- Shared package holds:
  - the state enum (READ, CAPTURE, WRITE, DONE, ERROR);
  - BIOS_BASE = 20'hFE000 and BIOS_BYTES = 8192, which the BIOS ROM decode and this block share.
- No sub-module is needed; the ROM-port pass-through mux and the checksum accumulator stay inline.

Test Plan:
1. Copy with immediate ack: ROM model holds byte n = n[7:0] (iRomSel = 1); iMemAck tied 1 → 8192 writes, addresses FE000–FFFFF with data n[7:0] in order; oDone rises 24576 cycles after reset release; oCpuHold falls the same cycle; oChecksum = 00h (sum of 0..255 ×32 = 0 mod 256); oSumOk = 1.
2. Delayed ack: iMemAck asserted 3 cycles after oMemWr rises → oMemAddr/oMemData stable throughout; exactly one write per byte; oDone at 8192·6 cycles.
3. Checksum fail: ROM byte 0 changed to 01h → oDone = 1, oSumOk = 0, oChecksum = 01h; oCpuHold still 0.
4. ROM not responding: iRomSel forced 0 at idx 5 → ERROR after CAPTURE of idx 5; oError = 1, oCpuHold = 1, no further oMemWr, iStart ignored.
5. Reset mid-copy: assert iRst during WRITE at idx 100 → oMemWr = 0 immediately; after release, first write goes to FE000h.
6. DONE pass-through then restart: in DONE, iCpuRd = 1 with iCpuAddr = FFFF0h → oRomRd = 1, oRomAddr = FFFF0h the same cycle; then pulse iStart → oDone = 0, oCpuHold = 1, full copy repeats from FE000h.

Source files
------------

// File: rtl/bios_shadow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bios_shadow_ctrl_pkg
//   Shared definitions for the BIOS shadowing logic: the sequencer state
//   encoding and the location/size of the BIOS window. The BIOS ROM decode
//   and the shadow controller both import these so they agree on the window.
// ---------------------------------------------------------------------------
package bios_shadow_ctrl_pkg;

  // First physical address of the BIOS ROM window and of its SRAM shadow.
  localparam logic [19:0] BIOS_BASE  = 20'hFE000;

  // Size of the BIOS image in bytes (8 KiB).
  localparam int          BIOS_BYTES = 8192;

  // Copy sequencer states.
  typedef enum logic [2:0] {
    S_READ    = 3'd0,
    S_CAPTURE = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } shadowState_e;

endpackage

// File: rtl/bios_shadow_ctrl.sv
// ---------------------------------------------------------------------------
// bios_shadow_ctrl
//   Boot-time sequencer that copies the BIOS ROM image into the SRAM shadow
//   at the same physical addresses while the CPU is held in reset, keeping a
//   running 8-bit byte sum of the image. Once the copy is complete the ROM
//   read port is handed back to the CPU bus.
//
// Ports
//   iClk, iRst           clock, asynchronous active-high reset
//   iStart               pulse that re-runs the copy from the DONE state
//   iCpuAddr, iCpuRd     CPU bus request, forwarded to the ROM only in DONE
//   oRomAddr, oRomRd     ROM read request (1-cycle latency ROM)
//   iRomSel, iRomData    ROM response, valid the cycle after oRomRd
//   oMemAddr, oMemData   SRAM write address/data, stable while oMemWr is high
//   oMemWr, iMemAck      SRAM write request / same-cycle acceptance
//   oCpuHold             keeps the CPU in reset until the copy is done
//   oDone, oError        copy finished / ROM failed to respond
//   oSumOk, oChecksum    byte-sum-is-zero flag (valid with oDone), running sum
// ---------------------------------------------------------------------------
module bios_shadow_ctrl
  import bios_shadow_ctrl_pkg::*;
#(
  parameter int          ROM_BYTES = BIOS_BYTES,
  parameter int          IDX_W     = 13,
  parameter logic [19:0] BASE_ADDR = BIOS_BASE
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [19:0] iCpuAddr,
  input  logic        iCpuRd,
  output logic [19:0] oRomAddr,
  output logic        oRomRd,
  input  logic        iRomSel,
  input  logic [7:0]  iRomData,
  output logic [19:0] oMemAddr,
  output logic [7:0]  oMemData,
  output logic        oMemWr,
  input  logic        iMemAck,
  output logic        oCpuHold,
  output logic        oDone,
  output logic        oError,
  output logic        oSumOk,
  output logic [7:0]  oChecksum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_BYTES - 1);

  shadowState_e     rState;
  shadowState_e     wNextState;
  logic [IDX_W-1:0] rIdx;
  logic [7:0]       rSum;
  logic [7:0]       rData;
  logic             rSumOk;
  logic [19:0]      wWinAddr;
  logic             wLastIdx;

  // The ROM read and the SRAM write of a byte use the same physical address.
  assign wWinAddr = BASE_ADDR + 20'(rIdx);

  // The index never wraps; the final byte is detected by an explicit compare.
  assign wLastIdx = (rIdx == LAST_IDX);

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rState <= S_READ;
    end else begin
      rState <= wNextState;
    end
  end

  // Next-state logic: READ -> CAPTURE -> WRITE per byte, DONE after the last
  // acknowledged write, ERROR (sticky) if the ROM does not answer.
  always_comb begin
    wNextState = rState;
    case (rState)
      S_READ:    wNextState = S_CAPTURE;
      S_CAPTURE: wNextState = iRomSel ? S_WRITE : S_ERROR;
      S_WRITE: begin
        if (iMemAck) begin
          wNextState = wLastIdx ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        if (iStart) begin
          wNextState = S_READ;
        end
      end
      S_ERROR:   wNextState = S_ERROR;
      default:   wNextState = S_ERROR;
    endcase
  end

  // Copy datapath: byte latch, checksum accumulator, index, and the sum-ok
  // flag which is captured on the transition into DONE (the sum is final by
  // then because the last CAPTURE precedes the last WRITE).
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rIdx   <= '0;
      rSum   <= 8'h00;
      rData  <= 8'h00;
      rSumOk <= 1'b0;
    end else begin
      case (rState)
        S_CAPTURE: begin
          if (iRomSel) begin
            rData <= iRomData;
            rSum  <= rSum + iRomData;
          end
        end
        S_WRITE: begin
          if (iMemAck) begin
            if (wLastIdx) begin
              rSumOk <= (rSum == 8'h00);
            end else begin
              rIdx <= rIdx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          if (iStart) begin
            rIdx   <= '0;
            rSum   <= 8'h00;
            rSumOk <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode. The reset state is READ, so the ROM strobe is gated by
  // iRst to keep the ROM idle while reset is held. In DONE the ROM port is a
  // straight combinational pass-through of the CPU bus.
  always_comb begin
    oRomRd   = 1'b0;
    oRomAddr = 20'h00000;
    oMemWr   = 1'b0;
    oMemAddr = 20'h00000;
    oMemData = 8'h00;
    oCpuHold = 1'b1;
    oDone    = 1'b0;
    oError   = 1'b0;
    case (rState)
      S_READ: begin
        oRomRd   = ~iRst;
        oRomAddr = wWinAddr;
      end
      S_WRITE: begin
        oMemWr   = 1'b1;
        oMemAddr = wWinAddr;
        oMemData = rData;
      end
      S_DONE: begin
        oCpuHold = 1'b0;
        oDone    = 1'b1;
        oRomRd   = iCpuRd;
        oRomAddr = iCpuAddr;
      end
      S_ERROR: begin
        oError   = 1'b1;
      end
      default: ;
    endcase
  end

  assign oSumOk    = rSumOk;
  assign oChecksum = rSum;

endmodule

// File: tb/tb_bios_shadow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bios_shadow_ctrl
//   Scoreboard bench for bios_shadow_ctrl. Each copy run pushes the complete
//   list of expected SRAM writes (address, data, clock edge of acceptance)
//   computed from the ROM image and the per-write ack delays; a monitor pops
//   and compares every accepted write. Completion, checksum, error and CPU
//   pass-through behaviour are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bios_shadow_ctrl;

  localparam int          NBYTES = 8192;
  localparam logic [19:0] BASE   = 20'hFE000;

  logic        iClk;
  logic        iRst;
  logic        iStart;
  logic [19:0] iCpuAddr;
  logic        iCpuRd;
  logic [19:0] oRomAddr;
  logic        oRomRd;
  logic        iRomSel;
  logic [7:0]  iRomData;
  logic [19:0] oMemAddr;
  logic [7:0]  oMemData;
  logic        oMemWr;
  logic        iMemAck;
  logic        oCpuHold;
  logic        oDone;
  logic        oError;
  logic        oSumOk;
  logic [7:0]  oChecksum;

  bios_shadow_ctrl dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iCpuAddr  (iCpuAddr),
    .iCpuRd    (iCpuRd),
    .oRomAddr  (oRomAddr),
    .oRomRd    (oRomRd),
    .iRomSel   (iRomSel),
    .iRomData  (iRomData),
    .oMemAddr  (oMemAddr),
    .oMemData  (oMemData),
    .oMemWr    (oMemWr),
    .iMemAck   (iMemAck),
    .oCpuHold  (oCpuHold),
    .oDone     (oDone),
    .oError    (oError),
    .oSumOk    (oSumOk),
    .oChecksum (oChecksum)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    int          edgeNo;
  } wrExp_t;

  wrExp_t     expQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] romMem [0:NBYTES-1];
  int         dly    [0:NBYTES-1];
  int         failIdx = -1;
  int         ackIdx  = 0;
  int         cycleCnt;
  int         wrAge   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] addr, input logic rd);
    iCpuAddr = addr;
    iCpuRd   = rd;
  endtask

  // Reference model of one copy run: byte k is written to BASE+k with ROM
  // byte k, and takes 3 cycles plus its ack delay. A ROM failure at failIdx
  // stops the copy after that byte's READ and CAPTURE cycles.
  task automatic pushCopy(input int base, output int endEdge, output logic [7:0] sum);
    int t;
    int s;
    wrExp_t e;
    t = base;
    s = 0;
    endEdge = -1;
    for (int k = 0; k < NBYTES; k++) begin
      if (k == failIdx) begin
        endEdge = t + 2;
        break;
      end
      t += 3 + dly[k];
      s += romMem[k];
      e.addr   = BASE + 20'(k);
      e.data   = romMem[k];
      e.edgeNo = t;
      expQ.push_back(e);
    end
    if (endEdge < 0) endEdge = t;
    sum = 8'(s);
  endtask

  task automatic waitUntil(input int edgeNo);
    while (cycleCnt < edgeNo) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Clock edges counted from reset release; edge 1 is the first after it.
  always @(posedge iClk or posedge iRst) begin
    if (iRst) cycleCnt <= 0;
    else      cycleCnt <= cycleCnt + 1;
  end

  // Registered ROM model with 1-cycle latency; select drops outside the
  // window or at the injected failure index.
  always @(posedge iClk) begin
    logic [19:0] off;
    off = oRomAddr - BASE;
    if (oRomRd) begin
      iRomSel  <= (oRomAddr >= BASE) && (int'(off[12:0]) != failIdx);
      iRomData <= romMem[off[12:0]];
    end else begin
      iRomSel  <= 1'b0;
      iRomData <= 8'h00;
    end
  end

  // SRAM model: acknowledges write number ackIdx after dly[ackIdx] extra cycles.
  always @(posedge iClk) begin
    #1;
    if (iRst || !oMemWr) begin
      wrAge   = 0;
      iMemAck = 1'b0;
    end else begin
      iMemAck = (wrAge >= ((ackIdx < NBYTES) ? dly[ackIdx] : 0));
      wrAge++;
    end
  end

  // Monitor: write stability while waiting for ack, and scoreboard compare
  // of every accepted write.
  logic        prevWr = 1'b0;
  logic [19:0] prevAddr;
  logic [7:0]  prevData;
  always @(negedge iClk) begin
    wrExp_t e;
    if (iRst) begin
      prevWr = 1'b0;
    end else begin
      if (oMemWr && prevWr) begin
        checkOutput("hold_addr", 32'(oMemAddr), 32'(prevAddr));
        checkOutput("hold_data", 32'(oMemData), 32'(prevData));
      end
      if (oMemWr && iMemAck) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                   oMemAddr, oMemData);
        end else begin
          e = expQ.pop_front();
          checkOutput("wr_addr", 32'(oMemAddr), 32'(e.addr));
          checkOutput("wr_data", 32'(oMemData), 32'(e.data));
          checkOutput("wr_edge", 32'(cycleCnt + 1), 32'(e.edgeNo));
        end
        ackIdx++;
        prevWr = 1'b0;
      end else begin
        prevWr   = oMemWr;
        prevAddr = oMemAddr;
        prevData = oMemData;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         doneEdge;
    int         base;
    int         s;
    logic [7:0] expSum;
    bit         found;

    iRst = 1'b1;
    iStart = 1'b0;
    iMemAck = 1'b0;
    applyStimulus(20'h00000, 1'b0);

    // Reset values.
    repeat (3) @(posedge iClk);
    #1;
    checkOutput("rst_hold",  32'(oCpuHold),  32'd1);
    checkOutput("rst_done",  32'(oDone),     32'd0);
    checkOutput("rst_error", 32'(oError),    32'd0);
    checkOutput("rst_sumok", 32'(oSumOk),    32'd0);
    checkOutput("rst_csum",  32'(oChecksum), 32'd0);
    checkOutput("rst_memwr", 32'(oMemWr),    32'd0);
    checkOutput("rst_maddr", 32'(oMemAddr),  32'd0);
    checkOutput("rst_mdata", 32'(oMemData),  32'd0);
    checkOutput("rst_romrd", 32'(oRomRd),    32'd0);

    // Copy of an incrementing image with immediate ack.
    for (int k = 0; k < NBYTES; k++) begin
      romMem[k] = 8'(k);
      dly[k]    = 0;
    end
    failIdx = -1;
    ackIdx  = 0;
    pushCopy(0, doneEdge, expSum);
    @(negedge iClk);
    iRst = 1'b0;
    waitUntil(doneEdge - 1);
    checkOutput("a_done_early", 32'(oDone),    32'd0);
    checkOutput("a_hold_early", 32'(oCpuHold), 32'd1);
    waitUntil(doneEdge);
    checkOutput("a_done",   32'(oDone),     32'd1);
    checkOutput("a_hold",   32'(oCpuHold),  32'd0);
    checkOutput("a_csum",   32'(oChecksum), 32'(expSum));
    checkOutput("a_sumok",  32'(oSumOk),    32'(expSum == 8'h00));
    checkOutput("a_pending", 32'(expQ.size()), 32'd0);

    // CPU pass-through in DONE.
    for (int i = 0; i < 6; i++) begin
      logic [19:0] a;
      logic        r;
      a = (i == 0) ? 20'hFFFF0 : 20'($urandom);
      r = (i == 0) ? 1'b1 : 1'($urandom);
      @(posedge iClk);
      #1;
      applyStimulus(a, r);
      #1;
      checkOutput("pt_romrd",   32'(oRomRd),   32'(r));
      checkOutput("pt_romaddr", 32'(oRomAddr), 32'(a));
      checkOutput("pt_memwr",   32'(oMemWr),   32'd0);
    end
    applyStimulus(20'h00000, 1'b0);

    // Restart with a random image whose byte sum is 01h and random ack delays.
    s = 0;
    for (int k = 0; k < NBYTES; k++) begin
      romMem[k] = 8'($urandom);
      dly[k]    = int'($urandom_range(0, 1));
      s += romMem[k];
    end
    romMem[0] = romMem[0] + 8'(1 - s);
    ackIdx = 0;
    @(posedge iClk);
    #1;
    base = cycleCnt + 1;
    pushCopy(base, doneEdge, expSum);
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    checkOutput("b_done_clr",  32'(oDone),    32'd0);
    checkOutput("b_hold_set",  32'(oCpuHold), 32'd1);
    checkOutput("b_sumok_clr", 32'(oSumOk),   32'd0);
    waitUntil(doneEdge - 1);
    checkOutput("b_done_early", 32'(oDone), 32'd0);
    waitUntil(doneEdge);
    checkOutput("b_done",   32'(oDone),     32'd1);
    checkOutput("b_hold",   32'(oCpuHold),  32'd0);
    checkOutput("b_csum",   32'(oChecksum), 32'(expSum));
    checkOutput("b_sumok",  32'(oSumOk),    32'(expSum == 8'h00));
    checkOutput("b_pending", 32'(expQ.size()), 32'd0);

    // Delayed ack (3 cycles) then reset during the write of byte 100.
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    for (int k = 0; k < NBYTES; k++) begin
      romMem[k] = 8'(k * 7 + 3);
      dly[k]    = 3;
    end
    failIdx = -1;
    ackIdx  = 0;
    expQ.delete();
    pushCopy(0, doneEdge, expSum);
    @(negedge iClk);
    iRst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge iClk);
      if (ackIdx == 100 && oMemWr) found = 1'b1;
    end
    checkOutput("c_reach_idx100", 32'(found), 32'd1);
    #2;
    iRst = 1'b1;
    #1;
    checkOutput("c_rst_memwr", 32'(oMemWr),   32'd0);
    checkOutput("c_rst_romrd", 32'(oRomRd),   32'd0);
    checkOutput("c_rst_hold",  32'(oCpuHold), 32'd1);
    repeat (2) @(posedge iClk);

    // Restart after reset with the ROM not responding at byte 5.
    for (int k = 0; k < NBYTES; k++) dly[k] = 0;
    failIdx = 5;
    ackIdx  = 0;
    expQ.delete();
    pushCopy(0, doneEdge, expSum);
    @(negedge iClk);
    iRst = 1'b0;
    waitUntil(doneEdge - 1);
    checkOutput("d_err_early", 32'(oError), 32'd0);
    waitUntil(doneEdge);
    checkOutput("d_error",   32'(oError),   32'd1);
    checkOutput("d_hold",    32'(oCpuHold), 32'd1);
    checkOutput("d_done",    32'(oDone),    32'd0);
    checkOutput("d_romrd",   32'(oRomRd),   32'd0);
    checkOutput("d_memwr",   32'(oMemWr),   32'd0);
    checkOutput("d_pending", 32'(expQ.size()), 32'd0);
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (10) @(posedge iClk);
    #1;
    checkOutput("d_err_sticky",  32'(oError),   32'd1);
    checkOutput("d_hold_sticky", 32'(oCpuHold), 32'd1);
    checkOutput("d_done_sticky", 32'(oDone),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
